// File: rtl/aes_round_mix_key_if.sv
// Handshake/data bundle between the AES S-box stage and the
// ShiftRows/MixColumns/key-expansion stage.
// Optional macro AES_STALL_CNT_EN adds the stall_cnt observation signal.
interface aes_round_mix_key_if;
    logic [127:0] state_in;
    logic [127:0] key_in;
    logic [31:0]  key_raw_w3;
    logic [7:0]   rcon_in;
    logic         empty_in;
    logic         in_ready;
    logic [127:0] state_out;
    logic [127:0] key_out;
    logic [7:0]   rcon_out;
    logic         empty_out;
    logic         out_ready;
`ifdef AES_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    // Upstream/downstream environment side
    modport master (
        output state_in, key_in, key_raw_w3, rcon_in, empty_in, out_ready,
        input  in_ready, state_out, key_out, rcon_out, empty_out
`ifdef AES_STALL_CNT_EN
        , input stall_cnt
`endif
    );

    // Pipeline stage side
    modport slave (
        input  state_in, key_in, key_raw_w3, rcon_in, empty_in, out_ready,
        output in_ready, state_out, key_out, rcon_out, empty_out
`ifdef AES_STALL_CNT_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/aes_round_mix_key.sv
// AES-128 round stage after SubBytes: ShiftRows, MixColumns (bypassed in the
// final round), next round-key expansion, AddRoundKey and Rcon update, with a
// 2-entry skid buffer on the output.
// Optional macro AES_STALL_CNT_EN adds a saturating output-stall counter.
module aes_round_mix_key #(
    parameter logic [7:0] FINAL_RCON = 8'h36
) (
    input logic               clk,
    input logic               rst,
    aes_round_mix_key_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the {02 03 01 01} circulant matrix
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    buf_state_t   state_r, next_s;
    logic         in_ready_r, empty_r;
    logic [127:0] main_state_r, main_key_r, skid_state_r, skid_key_r;
    logic [7:0]   main_rcon_r, skid_rcon_r;

    logic [127:0] sr_s, mc_s, res_state_s, res_key_s;
    logic [7:0]   res_rcon_s;
    logic [31:0]  t_s, w0_s, w1_s, w2_s, w3_s;
    logic         accept_s, consume_s;
    logic         load_main_s, load_skid_s, skid_to_main_s;

    // Round datapath: ShiftRows, MixColumns, key expansion, AddRoundKey
    always_comb begin
        sr_s = 128'h0;
        mc_s = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_s[127 - 8 * (r + 4 * c) -: 8] =
                    bus.state_in[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
            end
        end
        if (bus.rcon_in == FINAL_RCON) begin
            mc_s = sr_s;
        end else begin
            for (int c = 0; c < 4; c++) begin
                mc_s[127 - 32 * c -: 32] = mix_col(sr_s[127 - 32 * c -: 32]);
            end
        end
        // Rotation happens here: key_in's last word is substituted but unrotated
        t_s  = {bus.key_in[23:0], bus.key_in[31:24]} ^ {bus.rcon_in, 24'h000000};
        w0_s = bus.key_in[127:96] ^ t_s;
        w1_s = bus.key_in[95:64] ^ w0_s;
        w2_s = bus.key_in[63:32] ^ w1_s;
        w3_s = bus.key_raw_w3 ^ w2_s;
        res_key_s   = {w0_s, w1_s, w2_s, w3_s};
        res_state_s = mc_s ^ res_key_s;
        res_rcon_s  = xtime(bus.rcon_in);
    end

    assign accept_s  = !bus.empty_in && in_ready_r;
    assign consume_s = !empty_r && bus.out_ready;

    // Skid-buffer next-state and register-load decode
    always_comb begin
        next_s         = state_r;
        load_main_s    = 1'b0;
        load_skid_s    = 1'b0;
        skid_to_main_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    next_s      = ST_ONE;
                    load_main_s = 1'b1;
                end else begin
                    next_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && consume_s) begin
                    next_s      = ST_ONE;
                    load_main_s = 1'b1;
                end else if (accept_s) begin
                    next_s      = ST_TWO;
                    load_skid_s = 1'b1;
                end else if (consume_s) begin
                    next_s = ST_EMPTY;
                end else begin
                    next_s = ST_ONE;
                end
            end
            ST_TWO: begin
                if (consume_s) begin
                    next_s         = ST_ONE;
                    skid_to_main_s = 1'b1;
                end else begin
                    next_s = ST_TWO;
                end
            end
            default: begin
                next_s = ST_EMPTY;
            end
        endcase
    end

    // Buffer state, handshake flags and beat registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_EMPTY;
            in_ready_r   <= 1'b1;
            empty_r      <= 1'b1;
            main_state_r <= 128'h0;
            main_key_r   <= 128'h0;
            main_rcon_r  <= 8'h00;
            skid_state_r <= 128'h0;
            skid_key_r   <= 128'h0;
            skid_rcon_r  <= 8'h00;
        end else begin
            state_r    <= next_s;
            in_ready_r <= (next_s != ST_TWO);
            empty_r    <= (next_s == ST_EMPTY);
            if (load_main_s) begin
                main_state_r <= res_state_s;
                main_key_r   <= res_key_s;
                main_rcon_r  <= res_rcon_s;
            end else if (skid_to_main_s) begin
                main_state_r <= skid_state_r;
                main_key_r   <= skid_key_r;
                main_rcon_r  <= skid_rcon_r;
            end
            if (load_skid_s) begin
                skid_state_r <= res_state_s;
                skid_key_r   <= res_key_s;
                skid_rcon_r  <= res_rcon_s;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.empty_out = empty_r;
    assign bus.state_out = main_state_r;
    assign bus.key_out   = main_key_r;
    assign bus.rcon_out  = main_rcon_r;

`ifdef AES_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Count cycles a valid beat waits on downstream, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (!empty_r && !bus.out_ready && (stall_cnt_r != 16'hffff)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end
    end

    assign bus.stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_aes_round_mix_key.sv
// Self-checking bench for aes_round_mix_key: directed FIPS-197 vectors,
// Rcon wrap, backpressure, bubbles, reset in a full buffer, random traffic.
module tb_aes_round_mix_key;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_round_mix_key_if bus();
    aes_round_mix_key dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [127:0] st;
        logic [127:0] key;
        logic [7:0]   rc;
    } beat_t;

    beat_t q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    stall_exp = 0;
    int    n_popped = 0;
    bit    last_acc = 1'b0;
    beat_t tmp;

    // Generic GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            if (a[7]) a = (a << 1) ^ 8'h1b;
            else      a = a << 1;
            b = b >> 1;
        end
        return p;
    endfunction

    // Reference model of one round straight from the AES definitions
    function automatic beat_t ref_round(input logic [127:0] s, input logic [127:0] k,
                                        input logic [31:0] raw, input logic [7:0] rc);
        logic [7:0]  ib[16];
        logic [7:0]  sr[16];
        logic [7:0]  mc[16];
        logic [7:0]  m[4][4];
        logic [31:0] w[4];
        logic [31:0] t;
        beat_t       b;
        m = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
              '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
        for (int i = 0; i < 16; i++) ib[i] = s[127 - 8 * i -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                sr[r + 4 * c] = ib[r + 4 * ((c + r) % 4)];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                mc[r + 4 * c] = 8'h00;
                for (int j = 0; j < 4; j++)
                    mc[r + 4 * c] = mc[r + 4 * c] ^ gf_mul(m[r][j], sr[j + 4 * c]);
            end
        if (rc == 8'h36) mc = sr;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        t = {k[23:16], k[15:8], k[7:0], k[31:24]};
        t[31:24] = t[31:24] ^ rc;
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = raw ^ w[2];
        b.key = {w[0], w[1], w[2], w[3]};
        for (int i = 0; i < 16; i++) b.st[127 - 8 * i -: 8] = mc[i] ^ b.key[127 - 8 * i -: 8];
        b.rc = gf_mul(rc, 8'h02);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, update the buffer model, compare all outputs
    task automatic cycle();
        bit    acc, cons, stall;
        beat_t nb;
        acc   = !bus.empty_in && (q.size() < 2) && !rst;
        cons  = (q.size() > 0) && bus.out_ready;
        stall = (q.size() > 0) && !bus.out_ready;
        nb    = ref_round(bus.state_in, bus.key_in, bus.key_raw_w3, bus.rcon_in);
        @(posedge clk);
        #1;
        last_acc = acc;
        if (rst) begin
            q.delete();
            stall_exp = 0;
            last_acc  = 1'b0;
        end else begin
            if (stall && stall_exp < 65535) stall_exp++;
            if (cons) begin
                void'(q.pop_front());
                n_popped++;
            end
            if (acc) q.push_back(nb);
        end
        chk("empty_out", 128'(bus.empty_out), 128'(q.size() == 0));
        chk("in_ready", 128'(bus.in_ready), 128'(q.size() < 2));
        if (q.size() > 0) begin
            chk("state_out", bus.state_out, q[0].st);
            chk("key_out", bus.key_out, q[0].key);
            chk("rcon_out", 128'(bus.rcon_out), 128'(q[0].rc));
        end else if (rst) begin
            chk("rst_state_out", bus.state_out, 128'h0);
            chk("rst_key_out", bus.key_out, 128'h0);
            chk("rst_rcon_out", 128'(bus.rcon_out), 128'h0);
        end
`ifdef AES_STALL_CNT_EN
        chk("stall_cnt", 128'(bus.stall_cnt), 128'(stall_exp));
`endif
    endtask

    task automatic set_beat(input logic [127:0] s, input logic [127:0] k,
                            input logic [31:0] raw, input logic [7:0] rc);
        bus.state_in   = s;
        bus.key_in     = k;
        bus.key_raw_w3 = raw;
        bus.rcon_in    = rc;
        bus.empty_in   = 1'b0;
    endtask

    task automatic rand_beat();
        logic [7:0] rc;
        rc = 8'($urandom);
        if ($urandom_range(0, 3) == 0) rc = 8'h36;
        set_beat({$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, $urandom, rc);
    endtask

    localparam logic [127:0] FIPS_S   = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_K   = 128'h2b7e151628aed2a6abf71588018a84eb;
    localparam logic [31:0]  FIPS_RAW = 32'h09cf4f3c;
    localparam logic [127:0] FIPS_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    initial begin
        rst = 1'b1;
        bus.state_in = 128'h0; bus.key_in = 128'h0; bus.key_raw_w3 = 32'h0;
        bus.rcon_in = 8'h00; bus.empty_in = 1'b1; bus.out_ready = 1'b0;

        // Reset
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // FIPS-197 round 1
        bus.out_ready = 1'b1;
        set_beat(FIPS_S, FIPS_K, FIPS_RAW, 8'h01);
        cycle();
        chk("fips_state", bus.state_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
        chk("fips_key", bus.key_out, 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_rcon", 128'(bus.rcon_out), 128'h02);

        // Final round: MixColumns bypassed
        set_beat(FIPS_S, FIPS_K, FIPS_RAW, 8'h36);
        cycle();
        chk("final_key", bus.key_out, 128'h97fafe17bf542cb114a339391d6c7605);
        chk("final_state", bus.state_out, FIPS_SR ^ 128'h97fafe17bf542cb114a339391d6c7605);
        chk("final_rcon", 128'(bus.rcon_out), 128'h6c);

        // Rcon wrap
        set_beat(FIPS_S, FIPS_K, FIPS_RAW, 8'h80);
        cycle();
        chk("rcon_80", 128'(bus.rcon_out), 128'h1b);
        set_beat(FIPS_S, FIPS_K, FIPS_RAW, 8'h1b);
        cycle();
        chk("rcon_1b", 128'(bus.rcon_out), 128'h36);
        bus.empty_in = 1'b1;
        cycle();

        // Backpressure: three back-to-back beats with downstream stalled
        bus.out_ready = 1'b0;
        n_popped = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 0 || last_acc) rand_beat();
            cycle();
        end
        chk("bp_in_ready_low", 128'(bus.in_ready), 128'h0);
        cycle();
        cycle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (last_acc) bus.empty_in = 1'b1;
            cycle();
        end
        chk("bp_beats_out", 128'(n_popped), 128'd3);

        // Bubbles: hold one beat, then five bubble cycles with a stalled output
        bus.out_ready = 1'b0;
        rand_beat();
        cycle();
        bus.empty_in = 1'b1;
        tmp = q[0];
        for (int i = 0; i < 5; i++) cycle();
        chk("bubble_hold", bus.state_out, tmp.st);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) rand_beat();
            else bus.empty_in = 1'b1;
            cycle();
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) bus.empty_in = 1'b1;
            else rand_beat();
            bus.out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        // Reset with both entries full and a beat presented
        bus.out_ready = 1'b0;
        bus.empty_in = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        rand_beat();
        cycle();
        rand_beat();
        cycle();
        rand_beat();
        cycle();
        chk("two_in_ready", 128'(bus.in_ready), 128'h0);
        rst = 1'b1;
        cycle();
        chk("rst_empty", 128'(bus.empty_out), 128'h1);
        rst = 1'b0;
        bus.empty_in = 1'b1;
        cycle();
        chk("post_rst_empty", 128'(bus.empty_out), 128'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_round_mix_key.md
Name: aes_round_mix_key

Overview:
- Registered stage directly downstream of the S-box stage in the AES-128 encryption pipeline.
- Consumes the SubBytes'd state, the round key whose last word is already S-boxed (bytes C..F), Rcon, and the empty/bubble flag.
- Performs ShiftRows, MixColumns (skipped in the final round), next-round-key expansion and AddRoundKey.
- Output feeds the next S-box stage, or the ciphertext register after round 10.

Parameters:
FINAL_RCON, 8'h36, Rcon value identifying round 10, where MixColumns is bypassed.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
state_in  input  128  SubBytes'd state; byte i = bits [127-8i -: 8]; byte i = row i%4, column i/4
key_in  input  128  current round key; bytes 0..11 raw, bytes 12..15 = S-box of raw bytes 12..15 (no rotation applied)
key_raw_w3  input  32  raw (un-substituted) word 3 of current round key, byte 12 in MSB
rcon_in  input  8  round constant for the key being generated
empty_in  input  1  1 = bubble, input fields ignored
in_ready  output  1  stage can accept a beat this cycle
state_out  output  128  round result, same byte mapping
key_out  output  128  new round key, raw
rcon_out  output  8  xtime(rcon_in)
empty_out  output  1  1 = output holds no valid beat
out_ready  input  1  downstream accepts the beat this cycle

Behaviour:
- Transfer rules: input is accepted when empty_in=0 and in_ready=1. Output is consumed when empty_out=0 and out_ready=1.
- ShiftRows: sr[r+4c] = state_in[r+4((c+r)%4)].
- MixColumns: standard GF(2^8) matrix {02 03 01 01} over polynomial 0x11B, applied per column.
  - Bypassed (mc = sr) when rcon_in == FINAL_RCON.
- Key expansion:
  - t = {key_in[13], key_in[14], key_in[15], key_in[12]}, with byte 0 of t XORed with rcon_in.
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = key_raw_w3 ^ w2'.
- AddRoundKey: state_out = mc ^ {w0', w1', w2', w3'}; key_out = {w0', w1', w2', w3'}.
- Rcon: rcon_out = (rcon_in<<1) ^ (rcon_in[7] ? 8'h1B : 8'h00), truncated to 8 bits.
- Buffering: 2-entry skid buffer consisting of a main register and a skid register.
  - States: EMPTY (no valid beat), ONE (main valid), TWO (main and skid valid).
  - in_ready = 1 in EMPTY and ONE; in_ready = 0 in TWO. in_ready is registered, with no combinational path from out_ready.
  - EMPTY: accept -> ONE.
  - ONE: accept with no consume -> TWO (new beat goes to skid). Accept with consume -> ONE (main reloads). Consume with no accept -> EMPTY.
  - TWO: consume -> ONE (skid moves to main). No consume -> hold.
  - Output fields are driven from the main register. empty_out = (state == EMPTY).
- Latency: 1 cycle from accept to output valid when the stage is empty. Beat order is preserved.
- Bubbles: do not consume buffer entries. Data-path values are don't-care while empty_out = 1, but must be stable while empty_out = 0 and out_ready = 0.
- Reset:
  - State returns to EMPTY; empty_out = 1, in_ready = 1.
  - state_out, key_out and rcon_out reset to 0.
  - Reset mid-operation discards all buffered beats; any input presented in the reset cycle is dropped.

Optional Feature:
- Macro: AES_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0]. It increments each cycle where empty_out = 0 and out_ready = 0, saturates at 16'hFFFF, and is cleared by rst.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- FIPS-197 App. B round 1 -> state_out = a49c7ff2689f352b6b5bea43026a5049, key_out = a0fafe1788542cb123a339392a6c7605, rcon_out = 02, one cycle later.
  - state_in = d42711aee0bf98f1b8b45de51e415230.
  - key_in = 2b7e151628aed2a6abf71588018a84eb, key_raw_w3 = 09cf4f3c, rcon_in = 01.
- Final round: same inputs with rcon_in = 36 -> state_out = ShiftRows result d4bf5d30e0b452aeb84111f11e2798e5 XOR the expanded key (MixColumns skipped); rcon_out = 6c.
- Rcon wrap: rcon_in = 80 -> rcon_out = 1b. rcon_in = 1b -> rcon_out = 36.
- Backpressure: three back-to-back beats with out_ready = 0 -> in_ready drops after 2 accepts and the third is held off. Raise out_ready -> all beats exit in order, none lost or duplicated.
- Bubbles: empty_in = 1 for 5 cycles -> empty_out stays 1 and the buffer is unchanged. Alternating valid/bubble input -> outputs match in order.
- Reset in state TWO -> next cycle empty_out = 1, in_ready = 1, outputs 0 (and stall_cnt = 0 when AES_STALL_CNT_EN is defined).
